rs232_recv_cfg: RTL and testbench
=================================

RS232_RECV_CFG -- requirements
Module: rs232_recv_cfg

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter CLOCK_FREQ, real, default 133000000: clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, real, default 115200: line bit rate.
REQ-004 Parameter DATA_BITS, integer, default 8: legal range 5..9, LSB first on the line.
REQ-005 Parameter PARITY, integer, default 0: 0 = none, 1 = odd, 2 = even.
REQ-006 Parameter STOP_BITS, integer, default 1: legal values 1 or 2.
REQ-007 Port: clock  in  1  system clock.
REQ-008 Port: reset  in  1  asynchronous, active-high.
REQ-009 Port: txd_pin  in  1  asynchronous serial line; idle high.
REQ-010 Port: ctsn_pin  out  1  flow control; high means stop sending.
REQ-011 Port: afull  in  1  downstream FIFO almost full.
REQ-012 Port: data  out  DATA_BITS  received word.
REQ-013 Port: wren  out  1  one-cycle write strobe; data is valid while high.
REQ-014 Port: frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
REQ-015 Port: parity_err  out  1  one-cycle pulse on parity mismatch.

Function
REQ-016 txd_pin SHALL pass through a two-flop synchronizer, with both flops reset to 1; the result is called txd.
REQ-017 UNIT = CLOCK_FREQ/BAUD_RATE; sample point for slot k SHALL be round(UNIT*(k+0.5)) - 1 cycles after the start edge.
  Slot numbering: slot 0 = start bit, 1..DATA_BITS = data bits, then parity (if enabled), then stop bit(s).
REQ-018 Timer width SHALL be $clog2(last sample point + 2).
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-020 IDLE SHALL move to START on the first cycle txd = 0; the timer is cleared at that point.
REQ-021 START sample: if txd = 1, the event is a glitch; the FSM SHALL return to IDLE with no output pulse.
REQ-022 DATA SHALL shift the sampled bit into the MSB of the shift register at each data sample point.
REQ-023 PARITY state is skipped when PARITY = 0.
  Otherwise, the XOR of the data bits and the parity bit SHALL equal 1 for odd and 0 for even.
REQ-024 STOP SHALL sample each stop bit; any low stop sample ends the frame as a framing error.
REQ-025 Framing error: frame_err = 1 for one cycle, wren stays 0, and the FSM SHALL enter WAIT_IDLE.
  frame_err takes priority over parity_err.
REQ-026 WAIT_IDLE SHALL return to IDLE only after txd has been 1 for UNIT consecutive cycles (break recovery).
REQ-027 Parity error with good stop bits: parity_err = 1 for one cycle, wren = 0, and the FSM SHALL return to IDLE.
REQ-028 Good frame: data updates and wren = 1 for one cycle, on the cycle after the final stop sample; the FSM SHALL return to IDLE.
  A new start edge is accepted in the cycle after that.
REQ-029 data SHALL hold its value between wren pulses.
REQ-030 ctsn_pin SHALL equal afull, registered with one cycle delay.
REQ-031 Words completing while afull = 1 SHALL still be written; afull is assumed to leave headroom.

Reset
REQ-032 Reset SHALL force:
  - FSM to IDLE, timer to 0, synchronizer flops to 1;
  - data, wren, frame_err and parity_err to 0;
  - ctsn_pin to 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no pulse.
  After release, the first falling edge SHALL start a new frame.

Configuration
REQ-034 Macro RS232_RECV_MAJORITY_EN SHALL select the sampling method.
  Defined: each slot value is the 2-of-3 majority of txd at sample point -1, 0 and +1.
  Defined: wren, frame_err and parity_err move 1 cycle later than stated in REQ-028.
  Undefined: single sample at the sample point; timing is exactly as in REQ-028.

Verification
(Common setup: CLOCK_FREQ=1.6e6, BAUD_RATE=1e5, so UNIT=16.)
REQ-035 8N1, send 0xA5 -> data=0xA5 and wren pulse once.
  wren occurs 2+152+1 cycles after the txd_pin falling edge (+1 with the macro); no error pulses.
REQ-036 DATA_BITS=7, PARITY=2, send 0x41 with parity bit 1 -> parity_err pulse once; wren never asserted.
  The following frame 0x41 with parity 0 -> wren, data=0x41.
REQ-037 8N2, send 0x3C with the second stop bit low -> frame_err pulse; no wren.
  Line held low for 40 bit times, then high -> no further pulses; the next frame 0x01 is received correctly.
REQ-038 Low glitch of 4 cycles on idle line -> FSM back to IDLE, no pulses.
  With the macro, a 1-cycle inverted glitch at a data sample point -> data unaffected.
REQ-039 Assert reset at cycle 60 of a frame -> all outputs at reset values.
  A frame 0x5A sent after release -> received correctly.
REQ-040 Toggle afull 0->1->0 -> ctsn_pin follows with 1-cycle delay.
  A frame completing while afull=1 -> still written.

Source files
------------

// File: rtl/rs232_recv_cfg.sv
// Configurable RS-232 receiver: two-flop synchronizer, per-slot sample points and break recovery.
// Define RS232_RECV_MAJORITY_EN to take each bit as a 2-of-3 vote around its sample point.
module rs232_recv_cfg #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 txd_pin,
    output logic                 ctsn_pin,
    input  logic                 afull,
    output logic [DATA_BITS-1:0] data,
    output logic                 wren,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam real UNIT      = CLOCK_FREQ / BAUD_RATE;
    localparam int  UNIT_CYC  = $rtoi(UNIT + 0.5);
    localparam int  PAR_SLOTS = (PARITY != 0) ? 1 : 0;
    localparam int  NSLOTS    = 1 + DATA_BITS + PAR_SLOTS + STOP_BITS;
    localparam int  LAST_SP   = $rtoi(UNIT * (real'(NSLOTS) - 0.5) + 0.5) - 1;
    localparam int  TW        = $clog2(LAST_SP + 2);
    localparam int  SW        = 4;
    localparam logic [SW-1:0] LAST_DATA = SW'(DATA_BITS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOTS - 1);
    localparam logic [TW-1:0] UNIT_END  = TW'(UNIT_CYC - 1);

`ifdef RS232_RECV_MAJORITY_EN
    localparam logic [TW-1:0] SP_OFFSET = TW'(1);
`else
    localparam logic [TW-1:0] SP_OFFSET = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parAcc_q, parAcc_d;
    logic                   parBad_q, parBad_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   wren_q, wren_d;
    logic                   frameErr_q, frameErr_d;
    logic                   parityErr_q, parityErr_d;
    logic                   sync1_q, txd_q;
    logic                   ctsn_q;
    logic                   sampleBit;
    logic                   sampleNow;
    logic [TW-1:0]          spTable [16];

    // Sample point of every slot, fixed at elaboration from the real-valued bit period.
    for (genvar k = 0; k < 16; k++) begin : gSample
        if (k < NSLOTS) begin : gUsed
            localparam int SP = $rtoi(UNIT * (real'(k) + 0.5) + 0.5) - 1;
            assign spTable[k] = TW'(SP);
        end else begin : gUnused
            assign spTable[k] = '0;
        end
    end

`ifdef RS232_RECV_MAJORITY_EN
    logic txdD1_q, txdD2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txdD1_q <= 1'b1;
            txdD2_q <= 1'b1;
        end else begin
            txdD1_q <= txd_q;
            txdD2_q <= txdD1_q;
        end
    end

    // Decision is taken one cycle late so the vote can include the cycle after the sample point.
    assign sampleBit = (txd_q & txdD1_q) | (txd_q & txdD2_q) | (txdD1_q & txdD2_q);
`else
    assign sampleBit = txd_q;
`endif

    assign sampleNow = (timer_q == (spTable[slot_q] + SP_OFFSET));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            txd_q       <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            slot_q      <= '0;
            shift_q     <= '0;
            parAcc_q    <= 1'b0;
            parBad_q    <= 1'b0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
            ctsn_q      <= 1'b1;
        end else begin
            sync1_q     <= txd_pin;
            txd_q       <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            parAcc_q    <= parAcc_d;
            parBad_q    <= parBad_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
            ctsn_q      <= afull;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        slot_d      = slot_q;
        shift_d     = shift_q;
        parAcc_d    = parAcc_q;
        parBad_d    = parBad_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        frameErr_d  = 1'b0;
        parityErr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!txd_q) begin
                    state_d  = S_START;
                    timer_d  = '0;
                    slot_d   = '0;
                    parAcc_d = 1'b0;
                    parBad_d = 1'b0;
                end
            end

            // Break recovery: any low cycle restarts the count of consecutive highs.
            S_WAIT_IDLE: begin
                if (!txd_q) begin
                    timer_d = '0;
                end else if (timer_q == UNIT_END) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                timer_d = timer_q + TW'(1);
                if (sampleNow) begin
                    slot_d = slot_q + SW'(1);
                    case (state_q)
                        S_START: begin
                            state_d = sampleBit ? S_IDLE : S_DATA;
                        end
                        S_DATA: begin
                            shift_d  = {sampleBit, shift_q[DATA_BITS-1:1]};
                            parAcc_d = parAcc_q ^ sampleBit;
                            if (slot_q == LAST_DATA) begin
                                state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                            end
                        end
                        S_PARITY: begin
                            parBad_d = parAcc_q ^ sampleBit ^ (PARITY == 1);
                            state_d  = S_STOP;
                        end
                        S_STOP: begin
                            if (!sampleBit) begin
                                frameErr_d = 1'b1;
                                state_d    = S_WAIT_IDLE;
                                timer_d    = '0;
                            end else if (slot_q == LAST_SLOT) begin
                                state_d = S_IDLE;
                                if (parBad_q) begin
                                    parityErr_d = 1'b1;
                                end else begin
                                    wren_d = 1'b1;
                                    data_d = shift_q;
                                end
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign data       = data_q;
    assign wren       = wren_q;
    assign frame_err  = frameErr_q;
    assign parity_err = parityErr_q;
    assign ctsn_pin   = ctsn_q;

endmodule

// File: tb/tb_rs232_recv_cfg.sv
// Self-checking bench for rs232_recv_cfg: three configurations (8N1, 7E1, 8N2) at 16 clocks per bit.
// Expectations come from a frame-level model of the line protocol, not from the receiver's internals.
module tb_rs232_recv_cfg;

    localparam real CLK_HZ  = 1.6e6;
    localparam real BAUD    = 1.0e5;
    localparam int  BIT_CYC = 16;
`ifdef RS232_RECV_MAJORITY_EN
    localparam int  MAJ_DELAY = 1;
`else
    localparam int  MAJ_DELAY = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       afull;
    logic [2:0] txdPins;
    logic       ctsnA, ctsnB, ctsnC;
    logic       wrenA, wrenB, wrenC;
    logic       feA, feB, feC;
    logic       peA, peB, peC;
    logic [7:0] dataA;
    logic [6:0] dataB;
    logic [7:0] dataC;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int wrenCnt[3] = '{0, 0, 0};
    int feCnt[3] = '{0, 0, 0};
    int peCnt[3] = '{0, 0, 0};
    int lastWrenCycle[3] = '{0, 0, 0};
    int lastGood[3] = '{0, 0, 0};

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    rs232_recv_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
        .clock(clock), .reset(reset), .txd_pin(txdPins[0]), .ctsn_pin(ctsnA), .afull(afull),
        .data(dataA), .wren(wrenA), .frame_err(feA), .parity_err(peA));

    rs232_recv_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dutB (
        .clock(clock), .reset(reset), .txd_pin(txdPins[1]), .ctsn_pin(ctsnB), .afull(afull),
        .data(dataB), .wren(wrenB), .frame_err(feB), .parity_err(peB));

    rs232_recv_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dutC (
        .clock(clock), .reset(reset), .txd_pin(txdPins[2]), .ctsn_pin(ctsnC), .afull(afull),
        .data(dataC), .wren(wrenC), .frame_err(feC), .parity_err(peC));

    // Count output pulses per receiver away from the active edge.
    always @(negedge clock) begin
        if (wrenA === 1'b1) begin wrenCnt[0]++; lastWrenCycle[0] = cycleCnt; end
        if (wrenB === 1'b1) begin wrenCnt[1]++; lastWrenCycle[1] = cycleCnt; end
        if (wrenC === 1'b1) begin wrenCnt[2]++; lastWrenCycle[2] = cycleCnt; end
        if (feA === 1'b1) feCnt[0]++;
        if (feB === 1'b1) feCnt[1]++;
        if (feC === 1'b1) feCnt[2]++;
        if (peA === 1'b1) peCnt[0]++;
        if (peB === 1'b1) peCnt[1]++;
        if (peC === 1'b1) peCnt[2]++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void getCfg(input int inst, output int nd, output int par, output int ns);
        case (inst)
            0:       begin nd = 8; par = 0; ns = 1; end
            1:       begin nd = 7; par = 2; ns = 1; end
            default: begin nd = 8; par = 0; ns = 2; end
        endcase
    endfunction

    function automatic int getData(input int inst);
        case (inst)
            0:       return int'(dataA);
            1:       return int'(dataB);
            default: return int'(dataC);
        endcase
    endfunction

    // Line order: start 0, data LSB first, optional parity, stop bits.
    function automatic int buildFrame(input int inst, input int word, input logic pbit,
                                      input logic [1:0] stops, output logic [15:0] bits);
        int nd, par, ns, n;
        getCfg(inst, nd, par, ns);
        bits = '1;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int d = 0; d < nd; d++) begin
            bits[n] = word[d];
            n++;
        end
        if (par != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int s = 0; s < ns; s++) begin
            bits[n] = stops[s];
            n++;
        end
        return n;
    endfunction

    task automatic applyStimulus(input int inst, input logic [15:0] bits, input int n,
                                 input int glitchAt, input int lowAfter, input int gap,
                                 output int startCycle);
        logic v;
        startCycle = 0;
        for (int c = 0; c < n * BIT_CYC; c++) begin
            @(negedge clock);
            v = bits[c / BIT_CYC];
            if (c == glitchAt) v = ~v;
            txdPins[inst] = v;
            if (c == 0) startCycle = cycleCnt;
        end
        if (lowAfter > 0) begin
            @(negedge clock);
            txdPins[inst] = 1'b0;
            repeat (lowAfter) @(negedge clock);
        end
        @(negedge clock);
        txdPins[inst] = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic runFrame(input int inst, input int word, input logic flipPar,
                            input logic [1:0] stops, input int glitchAt, input int lowAfter);
        int nd, par, ns, n, w, w0, f0, p0, startCycle, nslots;
        logic pbit, stopOk, parOk, expW;
        logic [15:0] bits;
        getCfg(inst, nd, par, ns);
        w = word & ((1 << nd) - 1);
        pbit = (^w) ^ (par == 1) ^ flipPar;
        n = buildFrame(inst, w, pbit, stops, bits);
        w0 = wrenCnt[inst];
        f0 = feCnt[inst];
        p0 = peCnt[inst];
        applyStimulus(inst, bits, n, glitchAt, lowAfter, 30 + $urandom_range(0, 10), startCycle);
        stopOk = (ns == 1) ? stops[0] : (stops[0] & stops[1]);
        parOk  = (par == 0) || (((^w) ^ pbit) == (par == 1));
        expW   = stopOk && parOk;
        if (expW) lastGood[inst] = w;
        checkOutput($sformatf("wren%0d_w%0h", inst, w), wrenCnt[inst] - w0, int'(expW));
        checkOutput($sformatf("ferr%0d_w%0h", inst, w), feCnt[inst] - f0, int'(!stopOk));
        checkOutput($sformatf("perr%0d_w%0h", inst, w), peCnt[inst] - p0, int'(stopOk && !parOk));
        checkOutput($sformatf("data%0d_w%0h", inst, w), getData(inst), lastGood[inst]);
        if (expW && inst == 0) begin
            nslots = 1 + nd + ((par != 0) ? 1 : 0) + ns;
            checkOutput("latency", lastWrenCycle[0] - startCycle,
                        2 + (BIT_CYC * (2 * nslots - 1)) / 2 + 1 + MAJ_DELAY);
        end
    endtask

    initial begin
        int w0, f0, p0, n, ri, rw, nd, par, ns;
        logic [15:0] bits;
        logic [1:0] rs;
        logic rf;

        reset   = 1'b1;
        afull   = 1'b0;
        txdPins = 3'b111;
        repeat (3) @(negedge clock);
        checkOutput("rstCtsnA", ctsnA, 1);
        checkOutput("rstWrenA", wrenA, 0);
        checkOutput("rstDataA", dataA, 0);
        checkOutput("rstFeC", feC, 0);
        checkOutput("rstPeB", peB, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("ctsnAfterRst", ctsnA, 0);
        repeat (5) @(negedge clock);

        runFrame(0, 8'hA5, 1'b0, 2'b11, -1, 0);

        runFrame(1, 8'h41, 1'b1, 2'b11, -1, 0);
        runFrame(1, 8'h41, 1'b0, 2'b11, -1, 0);

        runFrame(2, 8'h3C, 1'b0, 2'b01, -1, 40 * BIT_CYC);
        runFrame(2, 8'h01, 1'b0, 2'b11, -1, 0);

        // Short low glitch on an idle line must vanish without a pulse.
        w0 = wrenCnt[0]; f0 = feCnt[0]; p0 = peCnt[0];
        @(negedge clock);
        txdPins[0] = 1'b0;
        repeat (4) @(negedge clock);
        txdPins[0] = 1'b1;
        repeat (100) @(negedge clock);
        checkOutput("glitchWren", wrenCnt[0] - w0, 0);
        checkOutput("glitchFerr", feCnt[0] - f0, 0);
        checkOutput("glitchPerr", peCnt[0] - p0, 0);
        runFrame(0, 8'h6E, 1'b0, 2'b11, -1, 0);

`ifdef RS232_RECV_MAJORITY_EN
        runFrame(0, 8'hF0, 1'b0, 2'b11, 3 * BIT_CYC + 8, 0);
        runFrame(0, 8'h0F, 1'b0, 2'b11, 5 * BIT_CYC + 8, 0);
`endif

        // Reset in the middle of a frame abandons it silently.
        runFrame(0, 8'h96, 1'b0, 2'b11, -1, 0);
        n = buildFrame(0, 8'hA7, 1'b0, 2'b11, bits);
        w0 = wrenCnt[0]; f0 = feCnt[0]; p0 = peCnt[0];
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            txdPins[0] = bits[c / BIT_CYC];
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midRstData", dataA, 0);
        checkOutput("midRstWren", wrenA, 0);
        checkOutput("midRstFerr", feA, 0);
        checkOutput("midRstPerr", peA, 0);
        checkOutput("midRstCtsn", ctsnA, 1);
        txdPins[0] = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) lastGood[i] = 0;
        repeat (40) @(negedge clock);
        checkOutput("postRstWren", wrenCnt[0] - w0, 0);
        checkOutput("postRstFerr", feCnt[0] - f0, 0);
        checkOutput("postRstPerr", peCnt[0] - p0, 0);
        runFrame(0, 8'h5A, 1'b0, 2'b11, -1, 0);

        // Flow control follows afull one cycle late; words still land while it is high.
        @(negedge clock);
        afull = 1'b1;
        checkOutput("ctsnHold0", ctsnA, 0);
        @(negedge clock);
        checkOutput("ctsnRise", ctsnA, 1);
        runFrame(0, 8'hC3, 1'b0, 2'b11, -1, 0);
        @(negedge clock);
        afull = 1'b0;
        checkOutput("ctsnHold1", ctsnA, 1);
        @(negedge clock);
        checkOutput("ctsnFall", ctsnA, 0);

        for (int it = 0; it < 30; it++) begin
            ri = $urandom_range(0, 2);
            rw = int'($urandom & 32'h1FF);
            rf = (ri == 1) && ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            getCfg(ri, nd, par, ns);
            runFrame(ri, rw, rf, rs, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
